affine_to_jacob: RTL and testbench

Converts an affine point (x, y) into Jacobian coordinates for a chosen projective factor z. It computes X = x·z² mod p and Y = y·z³ mod p, and returns Z = z unchanged. It is the entry stage of the point-arithmetic datapath, and the output side of that datapath converts back with the Jacobian-to-affine blocks. It uses one bit-serial interleaved modular multiplier, which is reused for four products.

---
 rtl/ecc_pkg.sv | 7 +
 rtl/affine_to_jacob_if.sv | 9 +
 rtl/mod_mul_serial.sv | 53 +++++
 rtl/affine_to_jacob.sv | 103 ++++++++++
 tb/tb_affine_to_jacob.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared FSM state type, field width and secp256k1 modulus for the point-arithmetic datapath
package ecc_pkg;
    localparam int ECC_WIDTH = 256;
    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    typedef enum logic [2:0] {IDLE, MUL_ZZ, MUL_XT, MUL_TZ, MUL_YT, DONE} ecc_state_t;
endpackage

// File: rtl/affine_to_jacob_if.sv
// affine_to_jacob_if: request (start, x, y, z, p) and result (x3, y3, z3, busy, done) bundle
interface affine_to_jacob_if #(
    parameter int WIDTH = 256
);
    logic             start, busy, done;
    logic [WIDTH-1:0] x, y, z, p, x3, y3, z3;
    modport master (output start, x, y, z, p, input x3, y3, z3, busy, done);
    modport slave  (input start, x, y, z, p, output x3, y3, z3, busy, done);
endinterface

// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial interleaved r = a*b mod p; start loads operands, r/done valid WIDTH+1 cycles later
module mod_mul_serial #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] r,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] a_r, b_r, p_r;
    logic [WIDTH+1:0] acc, pw, dbl, dbl_red, sum, sum_red;
    logic [CW-1:0]    cnt;
    logic             run;
    assign r = acc[WIDTH-1:0];
    always_comb begin
        pw      = {2'b0, p_r};
        dbl     = acc << 1;
        dbl_red = dbl >= pw ? dbl - pw : dbl;
        sum     = a_r[WIDTH-1] ? dbl_red + {2'b0, b_r} : dbl_red;
        sum_red = sum >= pw ? sum - pw : sum;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            a_r  <= '0;
            b_r  <= '0;
            p_r  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= run && cnt == CW'(1);
            if (start) begin
                a_r <= a;
                b_r <= b;
                p_r <= p;
                acc <= '0;
                cnt <= CW'(WIDTH);
                run <= 1'b1;
            end else if (run) begin
                acc <= sum_red;
                a_r <= a_r << 1;
                cnt <= cnt - CW'(1);
                run <= cnt != CW'(1);
            end
        end
    end
endmodule

// File: rtl/affine_to_jacob.sv
// affine_to_jacob: (x, y, z) -> (x*z^2, y*z^3, z) mod p with one shared serial multiplier
//   clk, rst (sync, active-high); bus: start/x/y/z/p in, x3/y3/z3/busy/done out
//   ZONE_BYPASS_EN: z == 1 skips the multiplies and finishes one cycle after start
module affine_to_jacob
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    affine_to_jacob_if.slave bus
);
    ecc_state_t       state, state_nx;
    logic [WIDTH-1:0] x_r, y_r, z_r, p_r, t_r, xt_r;
    logic [WIDTH-1:0] mul_a, mul_b, mul_p, mul_r;
    logic             mul_start, mul_done, skip, one;
`ifdef ZONE_BYPASS_EN
    assign skip = bus.z == WIDTH'(1);
    assign one  = z_r == WIDTH'(1);
`else
    assign skip = 1'b0;
    assign one  = 1'b0;
`endif
    mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (mul_a),
        .b     (mul_b),
        .p     (mul_p),
        .r     (mul_r),
        .done  (mul_done)
    );
    // Each multiply is launched in the cycle the previous one reports done, taking
    // its fresh result straight from mul_r, so back-to-back products cost no bubble.
    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        mul_a     = x_r;
        mul_b     = mul_r;
        mul_p     = p_r;
        case (state)
            IDLE: if (bus.start) begin
                state_nx  = skip ? DONE : MUL_ZZ;
                mul_start = !skip;
                mul_a     = bus.z;
                mul_b     = bus.z;
                mul_p     = bus.p;
            end
            MUL_ZZ: if (mul_done) begin
                state_nx  = MUL_XT;
                mul_start = 1'b1;
            end
            MUL_XT: if (mul_done) begin
                state_nx  = MUL_TZ;
                mul_start = 1'b1;
                mul_a     = t_r;
                mul_b     = z_r;
            end
            MUL_TZ: if (mul_done) begin
                state_nx  = MUL_YT;
                mul_start = 1'b1;
                mul_a     = y_r;
            end
            MUL_YT: state_nx = mul_done ? DONE : MUL_YT;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            p_r      <= '0;
            t_r      <= '0;
            xt_r     <= '0;
            bus.x3   <= '0;
            bus.y3   <= '0;
            bus.z3   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.busy <= state inside {MUL_ZZ, MUL_XT, MUL_TZ, MUL_YT};
            bus.done <= state == DONE;
            if (state == IDLE && bus.start) begin
                x_r <= bus.x;
                y_r <= bus.y;
                z_r <= bus.z;
                p_r <= bus.p;
            end
            if (state == MUL_ZZ && mul_done) t_r <= mul_r;
            if (state == MUL_XT && mul_done) xt_r <= mul_r;
            if (state == DONE) begin
                bus.x3 <= one ? x_r : xt_r;
                bus.y3 <= one ? y_r : mul_r;
                bus.z3 <= z_r;
            end
        end
    end
endmodule

// File: tb/tb_affine_to_jacob.sv
// tb_affine_to_jacob: directed and random conversions on 8-bit and 256-bit instances against a modular-arithmetic model
module tb_affine_to_jacob;
    import ecc_pkg::*;
`ifdef ZONE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [255:0] P256 = SECP256K1_P;
    typedef struct {
        logic [255:0] x3, y3, z3, lx, ly;
        bit           lit;
        int           lat;
        longint       start;
    } exp_t;
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint edge_n = 0;
    int     vecs = 0, errs = 0;
    exp_t   sched [2][64];
    exp_t   cur [2];
    int     ns [2] = '{0, 0};
    int     nt [2] = '{0, 0};
    bit     pend [2] = '{0, 0};
    logic [255:0] hx [2], hy [2], hz [2];
    affine_to_jacob_if #(.WIDTH(8))   b8 ();
    affine_to_jacob_if #(.WIDTH(256)) b256 ();
    affine_to_jacob #(.WIDTH(8))   u8   (.clk(clk), .rst(rst), .bus(b8));
    affine_to_jacob #(.WIDTH(256)) u256 (.clk(clk), .rst(rst), .bus(b256));
    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;
    function automatic logic [255:0] mm(input logic [255:0] a, b, m);
        logic [511:0] pr;
        pr = {256'b0, a} * {256'b0, b};
        pr = pr % {256'b0, m};
        return pr[255:0];
    endfunction
    function automatic logic [255:0] rnd();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (v >= P256) v = v - P256;
        return v;
    endfunction
    task automatic chk(input int d, input string nm, input logic [255:0] act, req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s w%0d @edge %0d: got %0h want %0h", nm, d ? 256 : 8, edge_n, act, req);
        end
    endtask
    always @(negedge clk) begin
        logic [255:0] ax [2], ay [2], az [2];
        logic [1:0]   ob, od;
        ax = '{256'(b8.x3), b256.x3};
        ay = '{256'(b8.y3), b256.y3};
        az = '{256'(b8.z3), b256.z3};
        ob = {b256.busy, b8.busy};
        od = {b256.done, b8.done};
        for (int d = 0; d < 2; d++) begin
            longint e;
            logic   xd, xb;
            if (rst) begin
                pend[d] = 1'b0;
                hx[d] = '0;
                hy[d] = '0;
                hz[d] = '0;
            end else if (!pend[d] && nt[d] < ns[d]) begin
                cur[d] = sched[d][nt[d]];
                nt[d]++;
                pend[d] = 1'b1;
                if (cur[d].lit) begin
                    chk(d, "model_x3", cur[d].x3, cur[d].lx);
                    chk(d, "model_y3", cur[d].y3, cur[d].ly);
                end
            end
            e  = edge_n - cur[d].start;
            xd = pend[d] && e == longint'(cur[d].lat);
            xb = pend[d] && e >= 1 && e < longint'(cur[d].lat);
            if (xd) begin
                hx[d] = cur[d].x3;
                hy[d] = cur[d].y3;
                hz[d] = cur[d].z3;
                pend[d] = 1'b0;
            end
            chk(d, "done", 256'(od[d]), 256'(xd));
            chk(d, "busy", 256'(ob[d]), 256'(xb));
            chk(d, "x3", ax[d], hx[d]);
            chk(d, "y3", ay[d], hy[d]);
            chk(d, "z3", az[d], hz[d]);
        end
    end
    task automatic drive(input int d, input logic s, input logic [255:0] x, y, z, p);
        if (d == 0) begin
            b8.start = s;
            b8.x = x[7:0];
            b8.y = y[7:0];
            b8.z = z[7:0];
            b8.p = p[7:0];
        end else begin
            b256.start = s;
            b256.x = x;
            b256.y = y;
            b256.z = z;
            b256.p = p;
        end
    endtask
    // Called just after a falling edge; returns just after the falling edge that shows done.
    task automatic conv(input int d, input logic [255:0] x, y, z, input bit lit,
                        input logic [255:0] lx, ly, input int poke, input int abort);
        exp_t         ex;
        logic [255:0] p, zz;
        int           lim;
        p  = d ? P256 : 256'd251;
        zz = mm(z, z, p);
        ex.x3 = mm(x, zz, p);
        ex.y3 = mm(y, mm(zz, z, p), p);
        ex.z3 = z;
        ex.lit = lit;
        ex.lx = lx;
        ex.ly = ly;
        ex.lat = (BYP && z == 256'd1) ? 1 : 4 * ((d ? 256 : 8) + 1) + 1;
        ex.start = edge_n + 1;
        sched[d][ns[d]] = ex;
        ns[d]++;
        drive(d, 1'b1, x, y, z, p);
        lim = ex.lat + 4;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            if (abort == 0 && (d ? b256.done : b8.done)) break;
            if (abort != 0 && n == abort + 1) break;
            #1;
            if (n == 1) drive(d, 1'b0, ~x, ~y, ~z, ~p);
            if (poke != 0 && n == poke) drive(d, 1'b1, y, x, z + 1, p);
            if (poke != 0 && n == poke + 1) drive(d, 1'b0, ~x, ~y, ~z, ~p);
            if (n == abort) rst = 1'b1;
        end
        #1;
        rst = 1'b0;
        drive(d, 1'b0, ~x, ~y, ~z, ~p);
    endtask
    initial begin
        drive(0, 1'b0, '0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        conv(0, 3, 5, 2, 1, 12, 40, 0, 0);
        conv(0, 10, 20, 250, 1, 10, 231, 0, 0);
        conv(0, 77, 99, 0, 1, 0, 0, 0, 0);
        conv(0, 100, 200, 1, 1, 100, 200, 0, 0);
        conv(0, 250, 250, 250, 1, 250, 1, 10, 0);
        repeat (45) @(negedge clk);
        #1;
        conv(0, 3, 5, 2, 1, 12, 40, 0, 20);
        repeat (45) @(negedge clk);
        #1;
        conv(0, 3, 5, 2, 1, 12, 40, 0, 0);
        conv(0, 123, 45, 67, 0, 0, 0, 0, 0);
        conv(1, 1, 1, 2, 1, 4, 8, 0, 0);
        conv(1, 5, 7, P256 - 1, 1, 5, P256 - 7, 0, 0);
        conv(1, rnd(), rnd(), 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 28; i++) conv(1, rnd(), rnd(), rnd(), 0, 0, 0, 0, 0);
        repeat (50) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
